lfsr5_rng: RTL and testbench

//  5-bit maximal-length Fibonacci LFSR pseudo-random source (period 31, polynomial x^5+x^3+1).

---
 rtl/lfsr5_pkg.sv | 20 ++
 rtl/lfsr5_next.sv | 11 +
 rtl/lfsr5_rng.sv | 53 +++++
 tb/tb_lfsr5_rng.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/lfsr5_pkg.sv
// Shared types, constants and step function for the 5-bit LFSR random source.
package lfsr5_pkg;

   localparam int LFSR5_W = 5;

   typedef logic [LFSR5_W-1:0] lfsr5_t;

   localparam lfsr5_t LFSR5_DEFAULT_SEED = 5'h01;

   // Fibonacci step for x^5+x^3+1: shift left, feedback = s[4] ^ s[1].
   function automatic lfsr5_t lfsr5_step(input lfsr5_t s);
      return {s[3:0], s[4] ^ s[1]};
   endfunction

   // Zero is the lockup state, so it can never be a valid seed.
   function automatic lfsr5_t lfsr5_sanitize_seed(input lfsr5_t seed);
      return (seed == '0) ? LFSR5_DEFAULT_SEED : seed;
   endfunction

endpackage

// File: rtl/lfsr5_next.sv
// Combinational next-state for the 5-bit LFSR; usable for look-ahead as well.
module lfsr5_next
   import lfsr5_pkg::*;
(
   input  lfsr5_t s,
   output lfsr5_t s_next
);

   assign s_next = lfsr5_step(s);

endmodule

// File: rtl/lfsr5_rng.sv
// 5-bit maximal-length LFSR random source (period 31) with load and hold.
// Optional lockup recovery from the all-zero state: define LFSR5_LOCKUP_RECOVER_EN.
module lfsr5_rng
   import lfsr5_pkg::*;
#(
   parameter lfsr5_t SEED = LFSR5_DEFAULT_SEED
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                load,
   input  logic [LFSR5_W-1:0]  load_val,
   output logic [LFSR5_W-1:0]  data,
   output logic                wrap
);

   localparam lfsr5_t SEED_EFF = lfsr5_sanitize_seed(SEED);

   lfsr5_t s;
   lfsr5_t s_next;
   lfsr5_t load_eff;
   logic   lockup;

   lfsr5_next u_next (
      .s      (s),
      .s_next (s_next)
   );

`ifdef LFSR5_LOCKUP_RECOVER_EN
   assign load_eff = (load_val == '0) ? SEED_EFF : load_val;
   assign lockup   = (s == '0);
`else
   assign load_eff = load_val;
   assign lockup   = 1'b0;
`endif

   // Priority: reset > load > lockup recovery > step > hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         s <= SEED_EFF;
      end else if (load) begin
         s <= load_eff;
      end else if (lockup) begin
         s <= SEED_EFF;
      end else if (en) begin
         s <= s_next;
      end
   end

   assign data = s;
   assign wrap = (s == SEED_EFF);

endmodule

// File: tb/tb_lfsr5_rng.sv
// Self-checking bench for lfsr5_rng: vector table, full-period walk, seed and hold cases.
module tb_lfsr5_rng;

   logic       clk;
   logic       reset;
   logic       en, load;
   logic [4:0] load_val;
   logic       en2;
   logic [4:0] data, data2, data0;
   logic       wrap, wrap2, wrap0;

   int n_vec = 0;
   int n_err = 0;

   logic [5:0] exp_q[$];

   typedef struct {
      string      name;
      logic       rst;
      logic       ld;
      logic [4:0] lv;
      logic       en;
      logic [4:0] exp_data;
      logic       exp_wrap;
   } vec_t;

   vec_t vecs[$];

   logic [4:0] seq [31] = '{5'h01,5'h02,5'h05,5'h0A,5'h15,5'h0B,5'h17,5'h0E,5'h1D,5'h1B,
                            5'h16,5'h0C,5'h18,5'h11,5'h03,5'h07,5'h0F,5'h1F,5'h1E,5'h1C,
                            5'h19,5'h13,5'h06,5'h0D,5'h1A,5'h14,5'h09,5'h12,5'h04,5'h08,5'h10};

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   lfsr5_rng #(.SEED(5'h01)) dut (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
      .data(data), .wrap(wrap)
   );

   lfsr5_rng #(.SEED(5'h1F)) dut2 (
      .clk(clk), .reset(reset), .en(en2), .load(1'b0), .load_val(5'h00),
      .data(data2), .wrap(wrap2)
   );

   lfsr5_rng #(.SEED(5'h00)) dut0 (
      .clk(clk), .reset(reset), .en(1'b0), .load(1'b0), .load_val(5'h00),
      .data(data0), .wrap(wrap0)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // driver: apply inputs for one edge, sample #1 after it
   task automatic drive(input logic r, input logic ld, input logic [4:0] lv, input logic e);
      reset = r; load = ld; load_val = lv; en = e;
      @(posedge clk);
      #1;
   endtask

   // scoreboard step: push expectation, drive, pop and compare
   task automatic step_check(input string name, input logic r, input logic ld,
                             input logic [4:0] lv, input logic e,
                             input logic [4:0] exp_data, input logic exp_wrap);
      logic [5:0] exp;
      exp_q.push_back({exp_wrap, exp_data});
      drive(r, ld, lv, e);
      if (exp_q.size() == 0) begin
         check({name, " queue"}, 8'd0, 8'd1);
      end else begin
         exp = exp_q.pop_front();
         check({name, " data"}, {3'b0, data}, {3'b0, exp[4:0]});
         check({name, " wrap"}, {7'b0, wrap}, {7'b0, exp[5]});
      end
   endtask

   task automatic add(input string name, input logic r, input logic ld, input logic [4:0] lv,
                      input logic e, input logic [4:0] ed, input logic ew);
      vec_t v;
      v.name = name; v.rst = r; v.ld = ld; v.lv = lv; v.en = e;
      v.exp_data = ed; v.exp_wrap = ew;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] seen;
      reset = 1'b1; en = 1'b0; load = 1'b0; load_val = 5'h00; en2 = 1'b0;

      // vector table for SEED=01 instance
      add("rst1",      1, 0, 5'h00, 1, 5'h01, 1);
      add("rst2",      1, 0, 5'h00, 1, 5'h01, 1);
      add("step1",     0, 0, 5'h00, 1, 5'h02, 0);
      add("step2",     0, 0, 5'h00, 1, 5'h05, 0);
      add("step3",     0, 0, 5'h00, 1, 5'h0A, 0);
      add("step4",     0, 0, 5'h00, 1, 5'h15, 0);
      add("step5",     0, 0, 5'h00, 1, 5'h0B, 0);
      add("hold",      0, 0, 5'h00, 0, 5'h0B, 0);
      add("load13",    0, 1, 5'h13, 1, 5'h13, 0);
      add("after13a",  0, 0, 5'h00, 1, 5'h06, 0);
      add("after13b",  0, 0, 5'h00, 1, 5'h0D, 0);
      add("rst_ovr",   1, 1, 5'h1C, 1, 5'h01, 1);
      add("step_rs",   0, 0, 5'h00, 1, 5'h02, 0);
`ifdef LFSR5_LOCKUP_RECOVER_EN
      add("load00",    0, 1, 5'h00, 1, 5'h01, 1);
      add("zero_en1",  0, 0, 5'h00, 1, 5'h02, 0);
      add("zero_en2",  0, 0, 5'h00, 1, 5'h05, 0);
`else
      add("load00",    0, 1, 5'h00, 1, 5'h00, 0);
      add("zero_en1",  0, 0, 5'h00, 1, 5'h00, 0);
      add("zero_en2",  0, 0, 5'h00, 1, 5'h00, 0);
`endif
      add("load1F",    0, 1, 5'h1F, 0, 5'h1F, 0);
      add("after1F",   0, 0, 5'h00, 1, 5'h1E, 0);
      add("load_hold", 0, 1, 5'h10, 0, 5'h10, 0);
      add("wrap10",    0, 0, 5'h00, 1, 5'h01, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         step_check(vecs[i].name, vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].en,
                    vecs[i].exp_data, vecs[i].exp_wrap);
      end

      // full period from reset: every nonzero value once, back to 01
      step_check("per_rst", 1, 0, 5'h00, 0, 5'h01, 1);
      seen = 32'h0;
      seen[data] = 1'b1;
      for (int i = 1; i <= 31; i++) begin
         step_check($sformatf("per%0d", i), 0, 0, 5'h00, 1, seq[i % 31], (i % 31) == 0);
         seen[data] = 1'b1;
      end
      check("per_distinct", 8'($countones(seen)), 8'd31);
      check("per_nozero", {7'b0, seen[0]}, 8'd0);

      // SEED=1F instance with en toggling; SEED=0 instance sanitised to 01
      en2 = 1'b0;
      drive(1, 0, 5'h00, 0);
      check("s1F_rst_data", {3'b0, data2}, 8'h1F);
      check("s1F_rst_wrap", {7'b0, wrap2}, 8'd1);
      check("s0_rst_data", {3'b0, data0}, 8'h01);
      check("s0_rst_wrap", {7'b0, wrap0}, 8'd1);
      en2 = 1'b1; drive(0, 0, 5'h00, 0);
      check("s1F_en1", {3'b0, data2}, 8'h1E);
      check("s1F_wrap_off", {7'b0, wrap2}, 8'd0);
      en2 = 1'b0; drive(0, 0, 5'h00, 0);
      check("s1F_hold1", {3'b0, data2}, 8'h1E);
      en2 = 1'b0; drive(0, 0, 5'h00, 0);
      check("s1F_hold2", {3'b0, data2}, 8'h1E);
      en2 = 1'b1; drive(0, 0, 5'h00, 0);
      check("s1F_en2", {3'b0, data2}, 8'h1C);
      check("s0_still", {3'b0, data0}, 8'h01);
      en2 = 1'b0;

      check("queue_empty", 8'(exp_q.size()), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
